// File: rtl/key_debounce_sync.sv
// Multi-channel key front end: per-channel synchronizer chain, tick-driven
// stability counter, registered debounced level with one-cycle press/release pulses.
module key_debounce_sync #(
  parameter int NUM_KEYS       = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int DEBOUNCE_TICKS = 4,
  parameter int IDLE_LEVEL     = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tickIn,
  input  logic [NUM_KEYS-1:0] keyIn,
  output logic [NUM_KEYS-1:0] keyOut,
  output logic [NUM_KEYS-1:0] keyPressed,
  output logic [NUM_KEYS-1:0] keyReleased,
  output logic                anyKeyDown
);

  localparam int                CNT_W    = (DEBOUNCE_TICKS > 1) ? $clog2(DEBOUNCE_TICKS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  localparam logic [NUM_KEYS-1:0] IDLE_VEC = (IDLE_LEVEL != 0) ? '1 : '0;

  logic [NUM_KEYS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_KEYS-1:0] syncd;

  logic [CNT_W-1:0]    cnt_q [NUM_KEYS];
  logic [CNT_W-1:0]    cnt_d [NUM_KEYS];
  logic [NUM_KEYS-1:0] keyOut_q,  keyOut_d;
  logic [NUM_KEYS-1:0] press_q,   press_d;
  logic [NUM_KEYS-1:0] release_q, release_d;
  logic                any_q,     any_d;

  assign syncd = sync_q[SYNC_STAGES-1];

  // Synchronizer chain: plain flop-to-flop, idle level out of reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SYNC_STAGES; s++) sync_q[s] <= IDLE_VEC;
    end else begin
      sync_q[0] <= keyIn;
      for (int s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Stability counter per channel; any agreement with the accepted level restarts it
  always_comb begin
    keyOut_d  = keyOut_q;
    press_d   = '0;
    release_d = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt_d[i] = cnt_q[i];
      if (syncd[i] == keyOut_q[i]) begin
        cnt_d[i] = '0;
      end else if (tickIn) begin
        if (cnt_q[i] == CNT_LAST) begin
          keyOut_d[i] = syncd[i];
          cnt_d[i]    = '0;
          if (syncd[i] == IDLE_VEC[i]) release_d[i] = 1'b1;
          else                         press_d[i]   = 1'b1;
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
    any_d = |(keyOut_d ^ IDLE_VEC);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= '0;
      keyOut_q  <= IDLE_VEC;
      press_q   <= '0;
      release_q <= '0;
      any_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_KEYS; i++) cnt_q[i] <= cnt_d[i];
      keyOut_q  <= keyOut_d;
      press_q   <= press_d;
      release_q <= release_d;
      any_q     <= any_d;
    end
  end

  assign keyOut      = keyOut_q;
  assign keyPressed  = press_q;
  assign keyReleased = release_q;
  assign anyKeyDown  = any_q;

endmodule

// File: tb/tb_key_debounce_sync.sv
// Bench for key_debounce_sync: directed scenarios plus random traffic, every cycle
// compared against a run-length reference model of the debounce rules.
module tb_key_debounce_sync;

  localparam int NK   = 4;
  localparam int SS   = 2;
  localparam int DT   = 4;
  localparam int IDLE = 1;
  localparam logic [NK-1:0] IDLE_VEC = '1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tickIn;
  logic [NK-1:0] keyIn;
  logic [NK-1:0] keyOut, keyPressed, keyReleased;
  logic          anyKeyDown;

  key_debounce_sync #(
    .NUM_KEYS(NK), .SYNC_STAGES(SS), .DEBOUNCE_TICKS(DT), .IDLE_LEVEL(IDLE)
  ) dut (
    .clk(clk), .reset(reset), .tickIn(tickIn), .keyIn(keyIn),
    .keyOut(keyOut), .keyPressed(keyPressed), .keyReleased(keyReleased),
    .anyKeyDown(anyKeyDown)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // Reference model: delayed copies of keyIn and a count of consecutive
  // disagreeing ticks per channel.
  logic [NK-1:0] hist [SS];
  int            run  [NK];
  logic [NK-1:0] exp_out, exp_press, exp_rel;
  logic          exp_any;

  int tick_mode = 0;
  int tcyc      = 0;
  int pulse_cnt = 0;
  int press2_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got=%0h expected=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < SS; s++) hist[s] = IDLE_VEC;
    for (int i = 0; i < NK; i++) run[i] = 0;
    exp_out = IDLE_VEC; exp_press = '0; exp_rel = '0; exp_any = 1'b0;
  endtask

  task automatic model_edge();
    logic [NK-1:0] seen;
    seen = hist[SS-1];
    exp_press = '0;
    exp_rel   = '0;
    for (int i = 0; i < NK; i++) begin
      if (seen[i] == exp_out[i]) run[i] = 0;
      else if (tickIn) begin
        run[i] = run[i] + 1;
        if (run[i] >= DT) begin
          exp_out[i] = seen[i];
          run[i] = 0;
          if (seen[i] == IDLE_VEC[i]) exp_rel[i] = 1'b1;
          else                        exp_press[i] = 1'b1;
        end
      end
    end
    for (int s = SS-1; s > 0; s--) hist[s] = hist[s-1];
    hist[0] = keyIn;
    exp_any = (exp_out != IDLE_VEC);
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    chk("keyOut",      32'(keyOut),      32'(exp_out));
    chk("keyPressed",  32'(keyPressed),  32'(exp_press));
    chk("keyReleased", 32'(keyReleased), 32'(exp_rel));
    chk("anyKeyDown",  32'(anyKeyDown),  32'(exp_any));
    pulse_cnt += $countones(keyPressed | keyReleased);
    if (keyPressed[2]) press2_cnt++;
    case (tick_mode)
      0: tickIn = 1'b1;
      1: begin tcyc++; tickIn = (tcyc % 4 == 0); end
      2: tickIn = 1'b0;
      default: tickIn = ($urandom_range(0, 3) != 0);
    endcase
  endtask

  task automatic settle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  // Steps until the chosen pulse appears on channel idx; -1 if the budget expires.
  task automatic wait_bit(input int idx, input bit rel, input int budget, output int n);
    logic [NK-1:0] v;
    n = -1;
    for (int k = 1; k <= budget; k++) begin
      step();
      v = rel ? keyReleased : keyPressed;
      if (v[idx]) begin n = k; break; end
    end
  endtask

  initial begin
    int n;
    logic [NK-1:0] saved;
    logic prev_any;

    reset = 1'b1; keyIn = 4'b1111; tickIn = 1'b1;
    model_reset();
    #2;
    chk("rst_keyOut",  32'(keyOut), 32'hF);
    chk("rst_pulses",  32'(keyPressed | keyReleased), 32'h0);
    chk("rst_any",     32'(anyKeyDown), 32'h0);
    settle(2);
    reset = 1'b0;
    settle(3);

    // Single press: latency SYNC_STAGES+DEBOUNCE_TICKS edges
    keyIn[0] = 1'b0;
    wait_bit(0, 1'b0, 20, n);
    chk("press0_latency", 32'(n), 32'd6);
    chk("press0_vec",     32'(keyPressed), 32'h1);
    chk("press0_any",     32'(anyKeyDown), 32'h1);
    keyIn[0] = 1'b1;
    wait_bit(0, 1'b1, 20, n);
    chk("rel0_latency", 32'(n), 32'd6);
    settle(3);

    // Glitch of 3 cycles is rejected; 4-cycle low pulse is accepted
    pulse_cnt = 0;
    keyIn[1] = 1'b0; settle(3);
    keyIn[1] = 1'b1; settle(10);
    chk("glitch_pulses", 32'(pulse_cnt), 32'd0);
    chk("glitch_keyOut", 32'(keyOut), 32'hF);
    pulse_cnt = 0;
    keyIn[1] = 1'b0; settle(4);
    keyIn[1] = 1'b1; settle(12);
    chk("pulse4_pulses", 32'(pulse_cnt), 32'd2);

    // Bounce then hold low: exactly one press, 6 edges after the final fall
    press2_cnt = 0;
    keyIn[2] = 1'b0; settle(2);
    keyIn[2] = 1'b1; settle(2);
    keyIn[2] = 1'b0; settle(2);
    keyIn[2] = 1'b1; settle(2);
    keyIn[2] = 1'b0;
    wait_bit(2, 1'b0, 20, n);
    chk("bounce_latency", 32'(n), 32'd6);
    settle(5);
    chk("bounce_presses", 32'(press2_cnt), 32'd1);
    keyIn[2] = 1'b1; settle(8);

    // Tick every 4th cycle, then tick stuck low
    keyIn[0] = 1'b0; settle(8);
    tick_mode = 1; tcyc = 0;
    keyIn[0] = 1'b1;
    wait_bit(0, 1'b1, 40, n);
    chk("tick4_latency_ok", 32'(n >= 15 && n <= 18), 32'd1);
    tick_mode = 2; tickIn = 1'b0;
    saved = keyOut;
    keyIn[1] = 1'b0;
    settle(50);
    chk("tick0_frozen", 32'(keyOut), 32'(saved));
    tick_mode = 0; tickIn = 1'b1;
    wait_bit(1, 1'b0, 20, n);
    chk("tick_resume_latency", 32'(n), 32'd4);
    keyIn[1] = 1'b1; settle(8);

    // Simultaneous transitions on two channels
    keyIn = 4'b0101;
    wait_bit(1, 1'b0, 20, n);
    chk("simul_press", 32'(keyPressed), 32'hA);
    settle(3);
    keyIn = 4'b1111;
    prev_any = 1'b1;
    for (int k = 0; k < 20; k++) begin
      prev_any = anyKeyDown;
      step();
      if (keyReleased[1]) break;
    end
    chk("simul_release", 32'(keyReleased), 32'hA);
    chk("simul_any_fall", 32'({prev_any, anyKeyDown}), 32'b10);
    settle(4);

    // Reset mid-count with key 0 accepted and key 3 counting
    keyIn[0] = 1'b0; settle(8);
    keyIn[3] = 1'b0; settle(3);
    reset = 1'b1;
    #1;
    chk("midrst_keyOut", 32'(keyOut), 32'hF);
    chk("midrst_any",    32'(anyKeyDown), 32'h0);
    model_reset();
    settle(2);
    reset = 1'b0;
    wait_bit(3, 1'b0, 20, n);
    chk("midrst_latency", 32'(n), 32'd6);
    chk("midrst_press",   32'(keyPressed), 32'h9);
    keyIn = 4'b1111; settle(8);

    // Random traffic with random tick strobe
    tick_mode = 3;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NK; i++)
        if ($urandom_range(0, 5) == 0) keyIn[i] = ~keyIn[i];
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
